// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the five-stage MIPS pipeline. It decodes
//   the instructions held in the D, E, M and W pipeline registers and drives
//   the write-enable and clear strobes of PC/IF_ID/ID_EX/EX_MEM/MEM_WB. It also
//   owns the multiply/divide unit busy scheduler and the exception/ERET flush.
//
//   Build option (macro PIPE_FWD_EN):
//     defined   : Tnew/Tuse stall rule; external forwarding muxes are present.
//     undefined : no-forwarding build; any read of a register that is still
//                 the destination of an instruction in E, M or W stalls.
//
// Ports:
//   clk        in   pipeline clock
//   reset      in   asynchronous, active-high reset
//   IR_D..IR_W in   instruction words in IF_ID, ID_EX, EX_MEM, MEM_WB
//   exc_req    in   CP0 exception/interrupt taken this cycle (M commit point)
//   eret_D     in   ERET decoded in D
//   en_PC      out  PC write enable
//   en_D       out  IF_ID write enable
//   clr_D      out  IF_ID clear to nop
//   clr_E      out  ID_EX clear (bubble)
//   clr_M      out  EX_MEM clear
//   clr_W      out  MEM_WB clear
//   mdu_start  out  one-cycle MDU start pulse
//   mdu_busy   out  MDU busy flag
//   stall      out  registered stall decision (performance counter)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    input  logic [31:0] IR_W,
    input  logic        exc_req,
    input  logic        eret_D,
    output logic        en_PC,
    output logic        en_D,
    output logic        clr_D,
    output logic        clr_E,
    output logic        clr_M,
    output logic        clr_W,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        stall
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    // Per-instruction hazard attributes. A destination of $0 is left as 0,
    // which never matches because sources of $0 are ignored.
    typedef struct packed {
        logic       use_rs;
        logic [1:0] tuse_rs;
        logic       use_rt;
        logic [1:0] tuse_rt;
        logic [4:0] dst;
        logic [1:0] tnew_e;     // Tnew while the instruction sits in E
        logic       is_load;
        logic       is_hilo;    // MDU op or mfhi/mflo: must wait for the MDU
        logic       is_muldiv;  // starts the MDU
        logic       is_div;
    } dec_t;

    function automatic dec_t decode_f(input logic [31:0] ir);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        d  = '0;
        op = ir[31:26];
        fn = ir[5:0];
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_JR: begin
                        d.use_rs = 1'b1; d.tuse_rs = 2'd0;
                    end
                    F_JALR: begin
                        d.use_rs = 1'b1; d.tuse_rs = 2'd0;
                        d.dst = ir[15:11]; d.tnew_e = 2'd0;
                    end
                    F_MFHI, F_MFLO: begin
                        d.dst = ir[15:11]; d.tnew_e = 2'd1; d.is_hilo = 1'b1;
                    end
                    F_MTHI, F_MTLO: begin
                        d.use_rs = 1'b1; d.tuse_rs = 2'd1; d.is_hilo = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        d.use_rs = 1'b1; d.tuse_rs = 2'd1;
                        d.use_rt = 1'b1; d.tuse_rt = 2'd1;
                        d.is_hilo = 1'b1; d.is_muldiv = 1'b1;
                        d.is_div = (fn == F_DIV) || (fn == F_DIVU);
                    end
                    // Immediate shifts only read rt; the rs field is zero.
                    F_SLL, F_SRL, F_SRA: begin
                        d.use_rt = 1'b1; d.tuse_rt = 2'd1;
                        d.dst = ir[15:11]; d.tnew_e = 2'd1;
                    end
                    F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        d.use_rs = 1'b1; d.tuse_rs = 2'd1;
                        d.use_rt = 1'b1; d.tuse_rt = 2'd1;
                        d.dst = ir[15:11]; d.tnew_e = 2'd1;
                    end
                    default: begin
                        d.is_load = 1'b0;
                    end
                endcase
            end
            OP_JAL: begin
                d.dst = 5'd31; d.tnew_e = 2'd0;
            end
            OP_BEQ, OP_BNE: begin
                d.use_rs = 1'b1; d.tuse_rs = 2'd0;
                d.use_rt = 1'b1; d.tuse_rt = 2'd0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                d.use_rs = 1'b1; d.tuse_rs = 2'd1;
                d.dst = ir[20:16]; d.tnew_e = 2'd1;
            end
            OP_LUI: begin
                d.dst = ir[20:16]; d.tnew_e = 2'd1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                d.use_rs = 1'b1; d.tuse_rs = 2'd1;
                d.dst = ir[20:16]; d.tnew_e = 2'd2; d.is_load = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                d.use_rs = 1'b1; d.tuse_rs = 2'd1;
                d.use_rt = 1'b1; d.tuse_rt = 2'd2;
            end
            default: begin
                d.is_load = 1'b0;
            end
        endcase
        return d;
    endfunction

    // Does one D-stage source collide with an in-flight destination?
    function automatic logic src_hazard_f(
        input logic       used,
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst_e,
        input logic [1:0] tnew_e,
        input logic [4:0] dst_m,
        input logic [1:0] tnew_m,
        input logic [4:0] dst_w
    );
        logic hz;
        logic unused_arg;
`ifdef PIPE_FWD_EN
        // W always forwards in time, so only E and M can be too late.
        unused_arg = ^dst_w;
        if (used && (src != 5'd0)) begin
            hz = ((src == dst_e) && (tnew_e > tuse)) ||
                 ((src == dst_m) && (tnew_m > tuse));
        end else begin
            hz = 1'b0;
        end
`else
        // Without forwarding the value only becomes readable after W writes.
        unused_arg = ^{tuse, tnew_e, tnew_m};
        if (used && (src != 5'd0)) begin
            hz = (src == dst_e) || (src == dst_m) || (src == dst_w);
        end else begin
            hz = 1'b0;
        end
`endif
        return hz;
    endfunction

    dec_t             dec_d_s;
    dec_t             dec_e_s;
    dec_t             dec_m_s;
    dec_t             dec_w_s;
    logic [1:0]       tnew_m_s;
    logic             data_stall_s;
    logic             mdu_stall_s;
    logic             hazard_s;
    logic [CNT_W-1:0] busy_cnt_r;
    logic             stall_r;
    logic             unused_dec_s;

    assign dec_d_s  = decode_f(IR_D);
    assign dec_e_s  = decode_f(IR_E);
    assign dec_m_s  = decode_f(IR_M);
    assign dec_w_s  = decode_f(IR_W);
    assign tnew_m_s = dec_m_s.is_load ? 2'd1 : 2'd0;

    // Not every decoded attribute is needed for every stage.
    assign unused_dec_s = ^{dec_d_s, dec_e_s, dec_m_s, dec_w_s};

    // Register-dependency stall for rs and rt of the instruction in D
    always_comb begin
        data_stall_s =
            src_hazard_f(dec_d_s.use_rs, IR_D[25:21], dec_d_s.tuse_rs,
                         dec_e_s.dst, dec_e_s.tnew_e, dec_m_s.dst, tnew_m_s,
                         dec_w_s.dst) ||
            src_hazard_f(dec_d_s.use_rt, IR_D[20:16], dec_d_s.tuse_rt,
                         dec_e_s.dst, dec_e_s.tnew_e, dec_m_s.dst, tnew_m_s,
                         dec_w_s.dst);
    end

    // E is never stalled, so IR_E is seen for exactly one cycle: one pulse.
    assign mdu_start   = dec_e_s.is_muldiv && !mdu_busy && !exc_req;
    assign mdu_busy    = (busy_cnt_r != {CNT_W{1'b0}});
    // Including mdu_start covers the cycle before the counter has loaded.
    assign mdu_stall_s = dec_d_s.is_hilo && (mdu_busy || mdu_start);
    assign hazard_s    = data_stall_s || mdu_stall_s;
    assign stall       = stall_r;

    // Pipeline strobes; priority exception > stall > eret
    always_comb begin
        en_PC = 1'b1;
        en_D  = 1'b1;
        clr_D = 1'b0;
        clr_E = 1'b0;
        clr_M = 1'b0;
        clr_W = 1'b0;
        if (exc_req) begin
            // W is older than the faulting instruction and still commits.
            clr_D = 1'b1;
            clr_E = 1'b1;
            clr_M = 1'b1;
        end else if (hazard_s) begin
            en_PC = 1'b0;
            en_D  = 1'b0;
            clr_E = 1'b1;
        end else if (eret_D) begin
            // Squash the delay-slot fetch behind ERET.
            clr_D = 1'b1;
        end else begin
            en_PC = 1'b1;
        end
    end

    // MDU busy counter; an exception lets an in-flight operation finish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else if (mdu_start) begin
            busy_cnt_r <= dec_e_s.is_div ? DIV_LOAD : MULT_LOAD;
        end else if (mdu_busy) begin
            busy_cnt_r <= busy_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end

    // Registered stall decision for the performance counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r <= 1'b0;
        end else begin
            stall_r <= hazard_s && !exc_req;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed, table-driven bench for pipe_hazard_ctrl plus hand-written
//   sequences for MDU busy timing, exception priority and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {en_PC, en_D, clr_D, clr_E, clr_M, clr_W, mdu_start}
    localparam logic [6:0] O_NORM  = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_ERET  = 7'b1110000;
    localparam logic [6:0] O_EXC   = 7'b1111100;

    logic        clk;
    logic        reset;
    logic [31:0] ir_d, ir_e, ir_m, ir_w;
    logic        exc_req, eret_d;
    logic        en_PC, en_D, clr_D, clr_E, clr_M, clr_W;
    logic        mdu_start, mdu_busy, stall;

    int n_chk;
    int n_fail;

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .IR_D      (ir_d),
        .IR_E      (ir_e),
        .IR_M      (ir_m),
        .IR_W      (ir_w),
        .exc_req   (exc_req),
        .eret_D    (eret_d),
        .en_PC     (en_PC),
        .en_D      (en_D),
        .clr_D     (clr_D),
        .clr_E     (clr_E),
        .clr_M     (clr_M),
        .clr_W     (clr_W),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir_d;
        logic [31:0] ir_e;
        logic [31:0] ir_m;
        logic [31:0] ir_w;
        logic        exc;
        logic        eret;
        logic [6:0]  exp_out;
        logic        exp_stall;
    } vec_t;

    function automatic logic [31:0] r_f(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_f(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] outs_f();
        return {en_PC, en_D, clr_D, clr_E, clr_M, clr_W, mdu_start};
    endfunction

    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                         input logic [31:0] w, input logic x, input logic er);
        ir_d = d; ir_e = e; ir_m = m; ir_w = w; exc_req = x; eret_d = er;
    endtask

    // MDU op in E with mflo waiting in D: count stall, start and busy cycles
    task automatic mdu_seq(input string nm, input logic [31:0] op_ir,
                           input int exp_stall, input int exp_busy);
        int stall_cyc, start_cnt, busy_cyc;
        bit done;
        stall_cyc = 0; start_cnt = 0; busy_cyc = 0; done = 1'b0;
        @(negedge clk);
        drive(r_f(5'd0, 5'd0, 5'd3, 6'h12), op_ir, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mdu_start) start_cnt++;
            if (mdu_busy) busy_cyc++;
            if (en_PC == 1'b0) begin
                stall_cyc++;
            end else begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            ir_e = 32'h0;   // E receives the bubble inserted by the stall
        end
        chk({nm, "_released"}, 32'(done), 32'd1);
        chk({nm, "_stall_cycles"}, 32'(stall_cyc), 32'(exp_stall));
        chk({nm, "_start_pulses"}, 32'(start_cnt), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
        chk({nm, "_stall_reg"}, 32'(stall), 32'd1);
        ir_d = 32'h0;
    endtask

    vec_t vecs[16];

    initial begin
        logic [31:0] nop, lw1, addu2_13, addu1, beq12, sw1, addu4_11, mult12, div45;
        logic [6:0]  fwd_ok;
        logic        fwd_st;
        n_chk = 0;
        n_fail = 0;

        nop      = 32'h0;
        lw1      = i_f(6'h23, 5'd0, 5'd1, 16'h0000);
        addu2_13 = r_f(5'd1, 5'd3, 5'd2, 6'h21);
        addu1    = r_f(5'd2, 5'd3, 5'd1, 6'h21);
        beq12    = i_f(6'h04, 5'd1, 5'd2, 16'h0004);
        sw1      = i_f(6'h2b, 5'd0, 5'd1, 16'h0000);
        addu4_11 = r_f(5'd1, 5'd1, 5'd4, 6'h21);
        mult12   = r_f(5'd1, 5'd2, 5'd0, 6'h18);
        div45    = r_f(5'd4, 5'd5, 5'd0, 6'h1a);
        // Cases that only the no-forwarding build stalls
        fwd_ok = FWD ? O_NORM : O_STALL;
        fwd_st = FWD ? 1'b0 : 1'b1;

        //          D         E        M        W      exc   eret  outputs  stall reg
        vecs[0]  = '{nop,      nop,     nop,     nop,   1'b0, 1'b0, O_NORM,  1'b0};
        vecs[1]  = '{addu2_13, lw1,     nop,     nop,   1'b0, 1'b0, O_STALL, 1'b1};
        vecs[2]  = '{addu2_13, nop,     lw1,     nop,   1'b0, 1'b0, fwd_ok,  fwd_st};
        vecs[3]  = '{beq12,    addu1,   nop,     nop,   1'b0, 1'b0, O_STALL, 1'b1};
        vecs[4]  = '{sw1,      addu1,   nop,     nop,   1'b0, 1'b0, fwd_ok,  fwd_st};
        vecs[5]  = '{addu4_11, nop,     nop,     addu1, 1'b0, 1'b0, fwd_ok,  fwd_st};
        vecs[6]  = '{r_f(5'd0, 5'd3, 5'd2, 6'h21), i_f(6'h23, 5'd0, 5'd0, 16'h0),
                     nop, nop, 1'b0, 1'b0, O_NORM, 1'b0};
        vecs[7]  = '{nop,      nop,     nop,     nop,   1'b0, 1'b1, O_ERET,  1'b0};
        vecs[8]  = '{addu2_13, lw1,     nop,     nop,   1'b0, 1'b1, O_STALL, 1'b1};
        vecs[9]  = '{beq12,    div45,   lw1,     addu1, 1'b1, 1'b0, O_EXC,   1'b0};
        vecs[10] = '{i_f(6'h2b, 5'd0, 5'd5, 16'h4), i_f(6'h23, 5'd0, 5'd5, 16'h0),
                     nop, nop, 1'b0, 1'b0, fwd_ok, fwd_st};
        vecs[11] = '{i_f(6'h2b, 5'd5, 5'd6, 16'h0), i_f(6'h23, 5'd0, 5'd5, 16'h0),
                     nop, nop, 1'b0, 1'b0, O_STALL, 1'b1};
        vecs[12] = '{r_f(5'd31, 5'd0, 5'd0, 6'h08), {6'h03, 26'h10},
                     nop, nop, 1'b0, 1'b0, fwd_ok, fwd_st};
        vecs[13] = '{i_f(6'h04, 5'd3, 5'd0, 16'h1), nop, r_f(5'd1, 5'd2, 5'd3, 6'h21),
                     nop, 1'b0, 1'b0, fwd_ok, fwd_st};
        vecs[14] = '{i_f(6'h04, 5'd7, 5'd0, 16'h1), nop, i_f(6'h23, 5'd0, 5'd7, 16'h0),
                     nop, 1'b0, 1'b0, O_STALL, 1'b1};
        vecs[15] = '{r_f(5'd1, 5'd0, 5'd0, 6'h11), nop, nop, nop, 1'b0, 1'b0, O_NORM, 1'b0};

        // Reset state
        reset = 1'b1;
        drive(nop, nop, nop, nop, 1'b0, 1'b0);
        #1;
        chk("reset_outputs", 32'(outs_f()), 32'(O_NORM));
        chk("reset_busy", 32'(mdu_busy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Combinational table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].ir_d, vecs[i].ir_e, vecs[i].ir_m, vecs[i].ir_w,
                  vecs[i].exc, vecs[i].eret);
            #1;
            chk($sformatf("vec%0d_outputs", i), 32'(outs_f()), 32'(vecs[i].exp_out));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_stall_reg", i), 32'(stall), 32'(vecs[i].exp_stall));
        end
        @(negedge clk);
        drive(nop, nop, nop, nop, 1'b0, 1'b0);
        #1;
        chk("exc_div_no_busy", 32'(mdu_busy), 32'd0);

        // MDU busy timing
        mdu_seq("mult", mult12, 6, 5);
        mdu_seq("div", r_f(5'd1, 5'd2, 5'd0, 6'h1a), 11, 10);

        // An exception does not cancel an in-flight multiply
        @(negedge clk);
        drive(nop, mult12, nop, nop, 1'b0, 1'b0);
        @(negedge clk);
        drive(nop, nop, nop, nop, 1'b1, 1'b0);
        #1;
        chk("exc_keeps_busy_outputs", 32'(outs_f()), 32'(O_EXC));
        @(posedge clk);
        #1;
        chk("exc_keeps_busy", 32'(mdu_busy), 32'd1);
        @(negedge clk);
        exc_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("mult_drained", 32'(mdu_busy), 32'd0);

        // Asynchronous reset while a divide is in flight (counter at 7)
        drive(r_f(5'd0, 5'd0, 5'd3, 6'h12), r_f(5'd1, 5'd2, 5'd0, 6'h1b),
              nop, nop, 1'b0, 1'b0);
        @(negedge clk);
        ir_e = nop;
        repeat (3) @(negedge clk);
        #2;
        chk("pre_reset_busy", 32'(mdu_busy), 32'd1);
        chk("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 32'(mdu_busy), 32'd0);
        chk("async_reset_stall", 32'(stall), 32'd0);
        chk("async_reset_outputs", 32'(outs_f()), 32'(O_NORM));
        @(negedge clk);
        reset = 1'b0;
        ir_d = nop;
        @(negedge clk);
        #1;
        chk("post_reset_idle", 32'(mdu_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS pipeline.
- Decodes the instruction words held in the D, E, M and W pipeline registers and produces write-enable and clear strobes for PC/IF_ID/ID_EX/EX_MEM/MEM_WB.
- Owns the multiply/divide unit (MDU) busy scheduler: issues the start pulse and blocks HI/LO-dependent instructions until the result is ready.
- Sequences the exception/ERET flush with CP0.

Parameters:
- MULT_CYC, 5, cycles MDU is busy after a mult/multu start
- DIV_CYC, 10, cycles MDU is busy after a div/divu start
- CNT_W, 4, width of the busy counter; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- IR_D  in  32  instruction in IF_ID
- IR_E  in  32  instruction in ID_EX
- IR_M  in  32  instruction in EX_MEM
- IR_W  in  32  instruction in MEM_WB
- exc_req  in  1  CP0 exception/interrupt taken this cycle (M-stage commit point)
- eret_D  in  1  ERET decoded in D
- en_PC  out  1  PC write enable
- en_D  out  1  IF_ID write enable
- clr_D  out  1  IF_ID synchronous clear to nop (32'h0)
- clr_E  out  1  ID_EX clear (bubble)
- clr_M  out  1  EX_MEM clear
- clr_W  out  1  MEM_WB clear
- mdu_start  out  1  one-cycle MDU start pulse
- mdu_busy  out  1  MDU busy flag
- stall  out  1  registered copy of the stall decision, for the performance counter

Behaviour:
- Reset (async) drives the busy counter to 0, mdu_busy to 0 and stall to 0. Combinational outputs evaluate with IR_* = 0 (nop): en_PC = en_D = 1, all clr_* = 0, mdu_start = 0.
- Decode classes:
  - ALU-R: rd destination.
  - ALU-I / lui: rt destination.
  - Load (lw/lh/lhu/lb/lbu): rt destination.
  - Store, branch (beq/bne), jr, jal, jalr.
  - MDU op: mult/multu/div/divu/mthi/mtlo. mfhi/mflo carry an rd destination.
- Destination register:
  - jal writes $31; jalr writes rd.
  - A destination of $0 is treated as "no destination".
- Tuse in D:
  - rs: 0 for beq/bne/jr/jalr, else 1.
  - rt: 0 for beq/bne, 2 for stores, 1 for ALU-R/MDU.
- Tnew:
  - E stage: load 2; ALU/lui/mfhi/mflo 1; jal/jalr 0.
  - M stage: load 1, else 0.
  - W stage: 0.
- Data stall (forwarding build):
  - Stall if (src == dest_E && Tnew_E > Tuse) or (src == dest_M && Tnew_M > Tuse), with src != 0.
- MDU stall:
  - Stall if D holds an MDU op or mfhi/mflo AND (mdu_busy || mdu_start).
- Stall response: en_PC = 0, en_D = 0, clr_E = 1. Takes effect in the same cycle (combinational).
- mdu_start:
  - Asserted = (IR_E is mult/multu/div/divu) && !mdu_busy && !exc_req.
  - Exactly one pulse per instruction. IR_E is held steady one cycle only, because E is never stalled.
- Busy counter:
  - On mdu_start, load MULT_CYC or DIV_CYC.
  - Decrement each cycle while nonzero.
  - mdu_busy = (counter != 0).
  - A start and a decrement never coincide, since start requires !busy.
- Exception (exc_req = 1):
  - clr_D = clr_E = clr_M = 1; en_PC = 1 (PC loads handler vector).
  - Overrides any stall; stall output records 0.
  - clr_W = 0, because the W instruction is older and commits.
  - The MDU counter is not cleared: an in-flight operation completes.
- eret_D with no stall: clr_D = 1 next-fetch squash (delay slot discarded); en_PC = 1.
- Priority: exc_req > stall > eret.
- stall register <= data/MDU stall decision every cycle.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined: Tnew/Tuse stall rule as above; external forwarding muxes assumed present.
- Undefined (no-forwarding build): stall whenever any D source (rs/rt as used by the class, src != 0) equals dest_E, dest_M or dest_W, regardless of Tnew/Tuse.
- Both builds: MDU and exception behaviour are unchanged.

Test Plan:
- lw $1,0($0) in E, addu $2,$1,$3 in D -> one cycle en_PC=0, en_D=0, clr_E=1; next cycle (lw in M, Tnew_M=1 = Tuse) no stall.
- addu $1 in E, beq $1,$2 in D -> stall 1 cycle; same sequence with sw $1,0($0) in D -> no stall.
- mult in E -> mdu_start pulses exactly 1 cycle; mdu_busy high 5 cycles; mflo in D stalls 6 cycles total (start cycle + 5), released when counter = 0. Repeat with div -> 11 cycles.
- exc_req with a lw-use stall pending and div in E -> clr_D/E/M=1, en_PC=1, mdu_start=0, stall reg=0, clr_W=0.
- Assert reset mid-div (counter=7) asynchronously -> mdu_busy=0 immediately, counter=0, stall=0 without a clock edge.
- PIPE_FWD_EN undefined: addu $1 in W, addu $4,$1,$1 in D -> stall; defined -> no stall.
